// File: rtl/wb_stage.sv
// Dual-issue writeback stage: registers the mem bundle, kills slots behind an
// exception, and owns LLbit/SC.W result rewrite. Optional macro: WB_TRACE_EN.
module wb_stage #(
  parameter int ISSUE_WIDTH = 2,
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int CSR_ADDR_W  = 14
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             pause_mem,
  input  logic                             pause_wb,
  input  logic                             flush,
  input  logic                             llbit_clear,
  input  logic [ISSUE_WIDTH-1:0]           mem_valid,
  input  logic [ISSUE_WIDTH*32-1:0]        mem_pc,
  input  logic [ISSUE_WIDTH-1:0]           mem_is_exception,
  input  logic [ISSUE_WIDTH-1:0]           mem_reg_we,
  input  logic [ISSUE_WIDTH*REG_ADDR_W-1:0] mem_reg_waddr,
  input  logic [ISSUE_WIDTH*DATA_W-1:0]    mem_reg_wdata,
  input  logic [ISSUE_WIDTH-1:0]           mem_is_llw,
  input  logic [ISSUE_WIDTH-1:0]           mem_is_scw,
  input  logic [ISSUE_WIDTH-1:0]           mem_csr_we,
  input  logic [ISSUE_WIDTH*CSR_ADDR_W-1:0] mem_csr_waddr,
  input  logic [ISSUE_WIDTH*DATA_W-1:0]    mem_csr_wdata,
  output logic [ISSUE_WIDTH-1:0]           wb_valid,
  output logic [ISSUE_WIDTH*32-1:0]        wb_pc,
  output logic [ISSUE_WIDTH-1:0]           wb_reg_we,
  output logic [ISSUE_WIDTH*REG_ADDR_W-1:0] wb_reg_waddr,
  output logic [ISSUE_WIDTH*DATA_W-1:0]    wb_reg_wdata,
  output logic [ISSUE_WIDTH-1:0]           wb_csr_we,
  output logic [ISSUE_WIDTH*CSR_ADDR_W-1:0] wb_csr_waddr,
  output logic [ISSUE_WIDTH*DATA_W-1:0]    wb_csr_wdata,
  output logic                             llbit
`ifdef WB_TRACE_EN
  ,
  output logic [31:0]                      commit_cnt,
  output logic [REG_ADDR_W-1:0]            debug_wb_rf_wnum,
  output logic [DATA_W-1:0]                debug_wb_rf_wdata,
  output logic                             debug_wb_rf_we
`endif
);

  logic [ISSUE_WIDTH-1:0]        eff_valid;
  logic [ISSUE_WIDTH-1:0]        commit;
  logic [ISSUE_WIDTH-1:0]        nxt_reg_we;
  logic [ISSUE_WIDTH-1:0]        nxt_csr_we;
  logic [ISSUE_WIDTH*DATA_W-1:0] nxt_reg_wdata;
  logic                          llbit_nxt;
  logic [31:0]                   commit_num;
  logic                          capture;

  assign capture = ~flush & ~pause_wb & ~pause_mem;

  // Slots are walked oldest first so a younger slot sees the LLbit left by
  // an older one, and any excepting older slot kills everything behind it.
  always_comb begin
    logic kill_acc;
    logic ll;
    eff_valid     = '0;
    commit        = '0;
    nxt_reg_we    = '0;
    nxt_csr_we    = '0;
    nxt_reg_wdata = mem_reg_wdata;
    commit_num    = '0;
    kill_acc      = 1'b0;
    ll            = llbit;
    for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
      eff_valid[i]  = mem_valid[i] & ~kill_acc;
      commit[i]     = eff_valid[i] & ~mem_is_exception[i];
      nxt_reg_we[i] = commit[i] & mem_reg_we[i] &
                      (mem_reg_waddr[i*REG_ADDR_W +: REG_ADDR_W] != '0);
      nxt_csr_we[i] = commit[i] & mem_csr_we[i];
      if (commit[i] && mem_is_scw[i]) begin
        nxt_reg_wdata[i*DATA_W +: DATA_W] = DATA_W'(ll);
      end
      if (commit[i] && mem_is_llw[i]) begin
        ll = 1'b1;
      end else if (commit[i] && mem_is_scw[i]) begin
        ll = 1'b0;
      end
      if (commit[i]) begin
        commit_num = commit_num + 32'd1;
      end
      kill_acc = kill_acc | (mem_valid[i] & mem_is_exception[i]);
    end
    llbit_nxt = ll;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= '0;
      wb_pc        <= '0;
      wb_reg_we    <= '0;
      wb_reg_waddr <= '0;
      wb_reg_wdata <= '0;
      wb_csr_we    <= '0;
      wb_csr_waddr <= '0;
      wb_csr_wdata <= '0;
    end else if (flush) begin
      wb_valid  <= '0;
      wb_reg_we <= '0;
      wb_csr_we <= '0;
    end else if (pause_wb) begin
      wb_valid  <= wb_valid;
    end else if (pause_mem) begin
      wb_valid  <= '0;
      wb_reg_we <= '0;
      wb_csr_we <= '0;
    end else begin
      wb_valid     <= eff_valid;
      wb_pc        <= mem_pc;
      wb_reg_we    <= nxt_reg_we;
      wb_reg_waddr <= mem_reg_waddr;
      wb_reg_wdata <= nxt_reg_wdata;
      wb_csr_we    <= nxt_csr_we;
      wb_csr_waddr <= mem_csr_waddr;
      wb_csr_wdata <= mem_csr_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      llbit <= 1'b0;
    end else if (llbit_clear) begin
      llbit <= 1'b0;
    end else if (capture) begin
      llbit <= llbit_nxt;
    end
  end

`ifdef WB_TRACE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_cnt <= '0;
    end else if (capture) begin
      commit_cnt <= commit_cnt + commit_num;
    end
  end

  assign debug_wb_rf_wnum  = wb_reg_waddr[REG_ADDR_W-1:0];
  assign debug_wb_rf_wdata = wb_reg_wdata[DATA_W-1:0];
  assign debug_wb_rf_we    = wb_reg_we[0];
`else
  logic unused_commit;
  assign unused_commit = ^commit_num;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage (default build, trace macro off).
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pause_mem, pause_wb, flush, llbit_clear;
  logic [1:0]  mem_valid, mem_is_exception, mem_reg_we, mem_is_llw, mem_is_scw, mem_csr_we;
  logic [63:0] mem_pc, mem_reg_wdata, mem_csr_wdata;
  logic [9:0]  mem_reg_waddr;
  logic [27:0] mem_csr_waddr;
  logic [1:0]  wb_valid, wb_reg_we, wb_csr_we;
  logic [63:0] wb_pc, wb_reg_wdata, wb_csr_wdata;
  logic [9:0]  wb_reg_waddr;
  logic [27:0] wb_csr_waddr;
  logic        llbit;

  int vecs = 0;
  int miss = 0;

  always #5 clk = ~clk;

  wb_stage #(.ISSUE_WIDTH(2), .DATA_W(32), .REG_ADDR_W(5), .CSR_ADDR_W(14)) dut (
    .clk(clk), .rst_n(rst_n), .pause_mem(pause_mem), .pause_wb(pause_wb),
    .flush(flush), .llbit_clear(llbit_clear), .mem_valid(mem_valid), .mem_pc(mem_pc),
    .mem_is_exception(mem_is_exception), .mem_reg_we(mem_reg_we),
    .mem_reg_waddr(mem_reg_waddr), .mem_reg_wdata(mem_reg_wdata),
    .mem_is_llw(mem_is_llw), .mem_is_scw(mem_is_scw), .mem_csr_we(mem_csr_we),
    .mem_csr_waddr(mem_csr_waddr), .mem_csr_wdata(mem_csr_wdata),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_reg_we(wb_reg_we),
    .wb_reg_waddr(wb_reg_waddr), .wb_reg_wdata(wb_reg_wdata), .wb_csr_we(wb_csr_we),
    .wb_csr_waddr(wb_csr_waddr), .wb_csr_wdata(wb_csr_wdata), .llbit(llbit)
  );

  task automatic idle_inputs();
    pause_mem = 0; pause_wb = 0; flush = 0; llbit_clear = 0;
    mem_valid = 0; mem_pc = 0; mem_is_exception = 0; mem_reg_we = 0;
    mem_reg_waddr = 0; mem_reg_wdata = 0; mem_is_llw = 0; mem_is_scw = 0;
    mem_csr_we = 0; mem_csr_waddr = 0; mem_csr_wdata = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // slot0 r5=0x1234, slot1 r6=0xABCD, plus CSR writes
  task automatic drive_dual();
    idle_inputs();
    mem_valid = 2'b11; mem_pc = {32'h1C00_0004, 32'h1C00_0000};
    mem_reg_we = 2'b11; mem_reg_waddr = {5'd6, 5'd5};
    mem_reg_wdata = {32'h0000_ABCD, 32'h0000_1234};
    mem_csr_we = 2'b11; mem_csr_waddr = {14'h6, 14'h5};
    mem_csr_wdata = {32'h66, 32'h55};
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #2;
    vecs++;
    if (wb_valid !== 2'b00 || wb_reg_we !== 2'b00 || wb_csr_we !== 2'b00 || llbit !== 1'b0 ||
        wb_reg_wdata !== 64'h0 || wb_pc !== 64'h0) begin
      miss++;
      $display("FAIL reset: valid=%b we=%b csr_we=%b llbit=%b wdata=%h pc=%h, need all 0",
               wb_valid, wb_reg_we, wb_csr_we, llbit, wb_reg_wdata, wb_pc);
    end
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_dual_commit();
    drive_dual();
    step();
    vecs++;
    if (wb_valid !== 2'b11 || wb_reg_we !== 2'b11 || wb_reg_waddr !== {5'd6, 5'd5} ||
        wb_reg_wdata !== {32'h0000_ABCD, 32'h0000_1234}) begin
      miss++;
      $display("FAIL dual_commit: valid=%b we=%b waddr=%h wdata=%h, need 11 11 0c5 0000abcd00001234",
               wb_valid, wb_reg_we, wb_reg_waddr, wb_reg_wdata);
    end
    vecs++;
    if (wb_csr_we !== 2'b11 || wb_csr_wdata !== {32'h66, 32'h55} ||
        wb_pc !== {32'h1C00_0004, 32'h1C00_0000}) begin
      miss++;
      $display("FAIL dual_csr: csr_we=%b csr_wdata=%h pc=%h", wb_csr_we, wb_csr_wdata, wb_pc);
    end
    mem_reg_waddr = {5'd6, 5'd0};
    step();
    vecs++;
    if (wb_reg_we !== 2'b10) begin
      miss++;
      $display("FAIL r0_write: we=%b, need 10", wb_reg_we);
    end
  endtask

  task automatic test_exception();
    drive_dual();
    mem_is_exception = 2'b01;
    step();
    vecs++;
    if (wb_valid !== 2'b01 || wb_reg_we !== 2'b00 || wb_csr_we !== 2'b00) begin
      miss++;
      $display("FAIL slot0_exc: valid=%b we=%b csr_we=%b, need 01 00 00",
               wb_valid, wb_reg_we, wb_csr_we);
    end
    mem_is_exception = 2'b10;
    step();
    vecs++;
    if (wb_valid !== 2'b11 || wb_reg_we !== 2'b01 || wb_csr_we !== 2'b01) begin
      miss++;
      $display("FAIL slot1_exc: valid=%b we=%b csr_we=%b, need 11 01 01",
               wb_valid, wb_reg_we, wb_csr_we);
    end
    // excepting LL.W must not set llbit
    idle_inputs();
    mem_valid = 2'b01; mem_is_llw = 2'b01; mem_is_exception = 2'b01;
    step();
    vecs++;
    if (llbit !== 1'b0) begin
      miss++;
      $display("FAIL exc_llw: llbit=%b, need 0", llbit);
    end
  endtask

  task automatic test_llsc();
    idle_inputs();
    mem_valid = 2'b11; mem_reg_we = 2'b11; mem_reg_waddr = {5'd7, 5'd4};
    mem_reg_wdata = {32'hDEAD_BEEF, 32'h0000_5555};
    mem_is_llw = 2'b01; mem_is_scw = 2'b10;
    step();
    vecs++;
    if (wb_reg_wdata !== {32'h1, 32'h0000_5555} || llbit !== 1'b0 || wb_reg_we !== 2'b11) begin
      miss++;
      $display("FAIL ll_sc_pair: wdata=%h llbit=%b we=%b, need 0000000100005555 0 11",
               wb_reg_wdata, llbit, wb_reg_we);
    end
    idle_inputs();
    mem_valid = 2'b01; mem_reg_we = 2'b01; mem_reg_waddr = 10'd8;
    mem_reg_wdata = {32'h0, 32'h0000_FFFF}; mem_is_scw = 2'b01;
    step();
    vecs++;
    if (wb_reg_wdata[31:0] !== 32'h0 || llbit !== 1'b0) begin
      miss++;
      $display("FAIL lone_sc: wdata=%h llbit=%b, need 0 0", wb_reg_wdata[31:0], llbit);
    end
    mem_is_scw = 2'b00; mem_is_llw = 2'b01;
    step();
    vecs++;
    if (llbit !== 1'b1 || wb_reg_wdata[31:0] !== 32'h0000_FFFF) begin
      miss++;
      $display("FAIL lone_ll: llbit=%b wdata=%h, need 1 0000ffff", llbit, wb_reg_wdata[31:0]);
    end
    mem_is_llw = 2'b00; mem_is_scw = 2'b10; mem_valid = 2'b10; mem_reg_we = 2'b10;
    mem_reg_waddr = {5'd9, 5'd0}; mem_reg_wdata = {32'h1234_5678, 32'h0};
    step();
    vecs++;
    if (wb_reg_wdata[63:32] !== 32'h1 || llbit !== 1'b0) begin
      miss++;
      $display("FAIL sc_success: wdata=%h llbit=%b, need 1 0", wb_reg_wdata[63:32], llbit);
    end
  endtask

  task automatic test_stall_flush();
    drive_dual();
    step();
    drive_dual();
    mem_reg_wdata = {32'h1111_1111, 32'h2222_2222}; mem_valid = 2'b01;
    mem_is_llw = 2'b01;
    pause_wb = 1;
    step();
    vecs++;
    if (wb_valid !== 2'b11 || wb_reg_we !== 2'b11 ||
        wb_reg_wdata !== {32'h0000_ABCD, 32'h0000_1234} || llbit !== 1'b0) begin
      miss++;
      $display("FAIL pause_wb_hold: valid=%b we=%b wdata=%h llbit=%b, need held 11 11 0000abcd00001234 0",
               wb_valid, wb_reg_we, wb_reg_wdata, llbit);
    end
    flush = 1;
    step();
    vecs++;
    if (wb_valid !== 2'b00 || wb_reg_we !== 2'b00 || wb_csr_we !== 2'b00 || llbit !== 1'b0) begin
      miss++;
      $display("FAIL flush_over_pause: valid=%b we=%b csr_we=%b llbit=%b, need 0",
               wb_valid, wb_reg_we, wb_csr_we, llbit);
    end
    drive_dual();
    step();
    pause_mem = 1;
    step();
    vecs++;
    if (wb_valid !== 2'b00 || wb_reg_we !== 2'b00 || wb_csr_we !== 2'b00) begin
      miss++;
      $display("FAIL pause_mem_bubble: valid=%b we=%b csr_we=%b, need 0",
               wb_valid, wb_reg_we, wb_csr_we);
    end
  endtask

  task automatic test_llbit_clear();
    idle_inputs();
    mem_valid = 2'b01; mem_is_llw = 2'b01; llbit_clear = 1;
    step();
    vecs++;
    if (llbit !== 1'b0 || wb_valid !== 2'b01) begin
      miss++;
      $display("FAIL llbit_clear_vs_ll: llbit=%b valid=%b, need 0 01", llbit, wb_valid);
    end
  endtask

  task automatic test_reset_midstream();
    drive_dual();
    mem_is_llw = 2'b01;
    step();
    vecs++;
    if (wb_reg_we !== 2'b11 || llbit !== 1'b1) begin
      miss++;
      $display("FAIL pre_reset_live: we=%b llbit=%b, need 11 1", wb_reg_we, llbit);
    end
    #2;
    rst_n = 0;
    #1;
    vecs++;
    if (wb_valid !== 2'b00 || wb_reg_we !== 2'b00 || wb_csr_we !== 2'b00 || llbit !== 1'b0 ||
        wb_reg_wdata !== 64'h0) begin
      miss++;
      $display("FAIL reset_midstream: valid=%b we=%b csr_we=%b llbit=%b wdata=%h, need 0",
               wb_valid, wb_reg_we, wb_csr_we, llbit, wb_reg_wdata);
    end
    step();
    rst_n = 1;
    step();
  endtask

  initial begin
    test_reset();
    test_dual_commit();
    test_exception();
    test_llsc();
    test_stall_flush();
    test_llbit_clear();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Dual-issue writeback pipeline stage directly downstream of mem.
- Registers mem's per-slot writeback and commit bundle and applies precise-exception slot killing.
- Owns the architectural LLbit and rewrites SC.W results; drives regfile/CSR write ports and the wb forwarding path to dispatch.
- Latency: 1 cycle from mem output to wb output.

Parameters:
ISSUE_WIDTH, 2, number of issue slots; slot 0 is older.
DATA_W, 32, register/CSR data width.
REG_ADDR_W, 5, GPR address width.
CSR_ADDR_W, 14, CSR address width.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
pause_mem  in  1  mem stalled this cycle; insert bubble into wb
pause_wb  in  1  ctrl stall of wb; hold all wb registers
flush  in  1  ctrl flush (exception/ertn/branch redirect); kill wb contents
llbit_clear  in  1  csr/ertn request to clear LLbit
mem_valid  in  ISSUE_WIDTH  slot valid from mem
mem_pc  in  ISSUE_WIDTH*32  slot pc
mem_is_exception  in  ISSUE_WIDTH  slot raised an exception
mem_reg_we  in  ISSUE_WIDTH  GPR write enable
mem_reg_waddr  in  ISSUE_WIDTH*REG_ADDR_W  GPR write address
mem_reg_wdata  in  ISSUE_WIDTH*DATA_W  GPR write data
mem_is_llw  in  ISSUE_WIDTH  slot is LL.W
mem_is_scw  in  ISSUE_WIDTH  slot is SC.W
mem_csr_we  in  ISSUE_WIDTH  CSR write enable
mem_csr_waddr  in  ISSUE_WIDTH*CSR_ADDR_W  CSR address
mem_csr_wdata  in  ISSUE_WIDTH*DATA_W  CSR write data
wb_valid  out  ISSUE_WIDTH  slot committed this cycle
wb_pc  out  ISSUE_WIDTH*32  committed pc
wb_reg_we  out  ISSUE_WIDTH  regfile write enable (also forwarded to dispatch)
wb_reg_waddr  out  ISSUE_WIDTH*REG_ADDR_W  regfile address
wb_reg_wdata  out  ISSUE_WIDTH*DATA_W  regfile data
wb_csr_we  out  ISSUE_WIDTH  CSR write enable
wb_csr_waddr  out  ISSUE_WIDTH*CSR_ADDR_W  CSR address
wb_csr_wdata  out  ISSUE_WIDTH*DATA_W  CSR data
llbit  out  1  current LLbit; mem uses it to gate SC.W store

Behaviour:
- Reset (rst_n=0, async): all wb_* outputs 0, llbit=0; after release, first capture at next clk edge.
- Capture priority per edge: flush > pause_wb > pause_mem > normal.
- flush: all wb_valid/we registers cleared next cycle; llbit untouched except via llbit_clear.
- pause_wb: every wb register and llbit hold (llbit_clear still honoured); outputs stable.
- pause_mem (no pause_wb): bubble loaded: wb_valid, wb_reg_we, wb_csr_we = 0.
- Normal: slot i captured with eff_valid[i] = mem_valid[i] & ~kill[i]; kill[0]=0; kill[1]=mem_valid[0]&mem_is_exception[0].
- Excepting slot: wb_valid=1 (for trace), wb_reg_we=wb_csr_we=0.
- wb_reg_we[i] = eff_valid[i] & mem_reg_we[i] & ~exc & (waddr!=0); r0 never written.
- LLbit update (edge, not paused/flushed): apply slot 0 then slot 1 in order: committed LL.W sets 1; committed SC.W clears 0; llbit_clear overrides result to 0.
- SC.W data: wb_reg_wdata = {31'b0, llbit_seen}, llbit_seen = llbit before this slot's update (slot 1 sees slot 0's LL.W/SC.W effect in same cycle).
- Same-cycle write to same GPR from both slots: both presented; consumers give slot 1 priority.
- Exceptions never update llbit.

Optional Feature:
WB_TRACE_EN: adds outputs commit_cnt (32, counts committed non-excepting slots, wraps 0xFFFFFFFF->0, reset 0, holds on pause_wb) and debug_wb_rf_wnum/wdata/we (slot 0 view). Without macro: ports and counter absent, core behaviour identical.

Test Plan:
- Reset mid-stream: assert rst_n=0 with wb_reg_we=2'b11 live -> all outputs 0 immediately, llbit=0.
- Dual commit: slot0 we r5=0x1234, slot1 we r6=0xABCD -> next cycle wb_reg_we=2'b11 with those addr/data; r0 write -> we=0.
- Slot-0 exception: mem_is_exception=2'b01, both valid with reg/csr writes -> wb_valid=2'b01, wb_reg_we=0, wb_csr_we=0.
- LL/SC pair: slot0 LL.W, slot1 SC.W same cycle -> slot1 wdata=0x1, llbit ends 0; lone SC.W with llbit=0 -> wdata=0x0.
- Stall/flush priority: pause_wb=1 with new mem data -> outputs held; flush=1 and pause_wb=1 -> outputs cleared; pause_mem=1 -> bubble.
- llbit_clear same edge as LL.W commit -> llbit=0.
